// File: rtl/jt900h_ram_ctl.sv
// rtl/jt900h_ram_ctl.sv - 32-bit little-endian fetch front-end over a 16-bit RAM port
module jt900h_ram_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        ldram_en,
  input  logic [23:0] idx_addr,
  input  logic [23:0] pc,
  output logic [23:0] ram_addr,
  input  logic [15:0] ram_dout,
  output logic [31:0] dout,
  output logic        ram_rdy
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RD2} state_t;

  state_t      state, state_nxt;
  logic [23:0] l_addr, l_addr_nxt;
  logic [23:0] ram_addr_nxt;
  logic [31:0] dout_nxt;
  logic [15:0] w0, w0_nxt, w1, w1_nxt;
  logic        valid, valid_nxt;
  logic [23:0] sel;
  logic        hit;

  assign sel     = ldram_en ? idx_addr : pc;
  assign hit     = valid && (l_addr == sel);
  assign ram_rdy = hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      l_addr   <= '0;
      ram_addr <= '0;
      dout     <= '0;
      w0       <= '0;
      w1       <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      l_addr   <= l_addr_nxt;
      ram_addr <= ram_addr_nxt;
      dout     <= dout_nxt;
      w0       <= w0_nxt;
      w1       <= w1_nxt;
      valid    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    l_addr_nxt   = l_addr;
    ram_addr_nxt = ram_addr;
    dout_nxt     = dout;
    w0_nxt       = w0;
    w1_nxt       = w1;
    valid_nxt    = valid;
    if (cen) begin
      if ((state == IDLE && !hit) || (state != IDLE && sel != l_addr)) begin
        // Fresh fetch or abort: any partially gathered words are simply overwritten
        l_addr_nxt   = sel;
        valid_nxt    = 1'b0;
        ram_addr_nxt = {sel[23:1], 1'b0};
        state_nxt    = RD0;
      end else begin
        case (state)
          RD0: begin
            w0_nxt       = ram_dout;
            ram_addr_nxt = ram_addr + 24'd2;
            state_nxt    = RD1;
          end
          RD1: begin
            w1_nxt = ram_dout;
            if (!l_addr[0]) begin
              dout_nxt  = {ram_dout, w0};
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              ram_addr_nxt = ram_addr + 24'd2;
              state_nxt    = RD2;
            end
          end
          RD2: begin
            // Odd address: drop the low byte of the first word, take one byte of the third
            dout_nxt  = {ram_dout[7:0], w1, w0[15:8]};
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt900h_ram_ctl.sv
// tb/tb_jt900h_ram_ctl.sv - randomized model-checked bench for jt900h_ram_ctl
module tb_jt900h_ram_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        ldram_en;
  logic [23:0] idx_addr;
  logic [23:0] pc;
  logic [23:0] ram_addr;
  logic [15:0] ram_dout;
  logic [31:0] dout;
  logic        ram_rdy;

  int checks = 0;
  int errors = 0;
  logic hmode = 1'b0;

  jt900h_ram_ctl dut (
    .clk(clk), .rst(rst), .cen(cen), .ldram_en(ldram_en),
    .idx_addr(idx_addr), .pc(pc), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .dout(dout), .ram_rdy(ram_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] n);
    if (hmode) return n[7:0] ^ {n[14:8], n[15]} ^ n[23:16] ^ 8'h5A;
    return n[7:0];
  endfunction

  function automatic logic [31:0] word_at(input logic [23:0] a);
    return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
  endfunction

  assign ram_dout = {mem_byte(ram_addr + 24'd1), mem_byte(ram_addr)};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a fetch takes one start edge plus 2 (even) or 3 (odd) read edges
  logic [23:0] m_l, m_ra;
  logic [31:0] m_dout;
  logic        m_valid, m_active;
  int          m_left;
  logic [23:0] s_now;
  assign s_now = ldram_en ? idx_addr : pc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_l <= '0; m_ra <= '0; m_dout <= '0; m_valid <= 1'b0; m_active <= 1'b0; m_left <= 0;
    end else if (cen) begin
      if ((m_active && s_now != m_l) || (!m_active && !(m_valid && m_l == s_now))) begin
        m_l      <= s_now;
        m_valid  <= 1'b0;
        m_ra     <= {s_now[23:1], 1'b0};
        m_left   <= s_now[0] ? 3 : 2;
        m_active <= 1'b1;
      end else if (m_active) begin
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_valid  <= 1'b1;
          m_dout   <= word_at(m_l);
        end else begin
          m_left <= m_left - 1;
          m_ra   <= m_ra + 24'd2;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rdy", {31'd0, ram_rdy}, {31'd0, m_valid && (m_l == s_now)});
    chk("dout", dout, m_dout);
    chk("ram_addr", {8'd0, ram_addr}, {8'd0, m_ra});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!ram_rdy && n < 10) begin
      tick();
      n++;
    end
    if (!ram_rdy) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [23:0] pick();
    case ($urandom_range(7))
      0: return 24'hFFFFFF;
      1: return 24'hFFFFFE;
      2: return 24'hFFFFFD;
      3: return 24'h000001;
      4: return 24'($urandom_range(63));
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b0; cen = 1'b1; ldram_en = 1'b0; idx_addr = '0; pc = '0;
    chk("model_wrap", word_at(24'hFFFFFF), 32'h020100FF);
    repeat (2) tick();
    chk("rst_dout", dout, 32'h0);
    chk("rst_addr", {8'd0, ram_addr}, 32'h0);
    chk("rst_rdy", {31'd0, ram_rdy}, 32'd0);
    rst = 1'b1;

    repeat (2) tick();
    chk("pc0_not_yet", {31'd0, ram_rdy}, 32'd0);
    tick();
    chk("pc0_rdy", {31'd0, ram_rdy}, 32'd1);
    chk("pc0_dout", dout, 32'h03020100);

    pc = 24'd5;
    tick(); chk("pc5_a0", {8'd0, ram_addr}, 32'h4);
    tick(); chk("pc5_a1", {8'd0, ram_addr}, 32'h6);
    tick(); chk("pc5_a2", {8'd0, ram_addr}, 32'h8);
    chk("pc5_not_yet", {31'd0, ram_rdy}, 32'd0);
    tick();
    chk("pc5_rdy", {31'd0, ram_rdy}, 32'd1);
    chk("pc5_dout", dout, 32'h08070605);

    pc = 24'hFFFFFF;
    tick(); chk("wrap_a0", {8'd0, ram_addr}, 32'hFFFFFE);
    tick(); chk("wrap_a1", {8'd0, ram_addr}, 32'h0);
    tick(); chk("wrap_a2", {8'd0, ram_addr}, 32'h2);
    tick(); chk("wrap_dout", dout, 32'h020100FF);

    pc = 24'h10;
    repeat (2) tick();
    pc = 24'h21;
    tick();
    chk("abort_addr", {8'd0, ram_addr}, 32'h20);
    chk("abort_rdy", {31'd0, ram_rdy}, 32'd0);
    repeat (3) tick();
    chk("abort_rdy2", {31'd0, ram_rdy}, 32'd1);
    chk("abort_dout", dout, 32'h24232221);

    ldram_en = 1'b1; idx_addr = 24'h40; pc = 24'h0;
    repeat (3) tick();
    chk("idx_dout", dout, 32'h43424140);
    ldram_en = 1'b0;
    #1 chk("idx_drop", {31'd0, ram_rdy}, 32'd0);
    wait_rdy("refetch");
    chk("refetch_dout", dout, 32'h03020100);
    idx_addr = 24'h0;
    ldram_en = 1'b1;
    #1 chk("toggle_same", {31'd0, ram_rdy}, 32'd1);
    tick();
    chk("toggle_same2", {31'd0, ram_rdy}, 32'd1);
    ldram_en = 1'b0;

    pc = 24'h100;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_addr", {8'd0, ram_addr}, 32'h0);
    chk("midrst_dout", dout, 32'h0);
    chk("midrst_rdy", {31'd0, ram_rdy}, 32'd0);
    pc = 24'h30;
    tick();
    rst = 1'b1;
    tick();
    chk("cen_start", {8'd0, ram_addr}, 32'h30);
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cen_frozen", {8'd0, ram_addr}, 32'h30);
      chk("cen_frozen_rdy", {31'd0, ram_rdy}, 32'd0);
    end
    cen = 1'b1;
    repeat (2) tick();
    chk("cen_dout", dout, 32'h33323130);

    for (int p = 0; p <= 1020; p += 4) begin
      pc = 24'(p);
      #1 chk("sweep_drop", {31'd0, ram_rdy}, {31'd0, p == 0 ? 1'b0 : 1'b0});
      wait_rdy("sweep");
      chk("sweep_dout", dout, {8'(p + 3), 8'(p + 2), 8'(p + 1), 8'(p)});
    end

    rst = 1'b0;
    hmode = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cen = ($urandom_range(3) != 0);
      if ($urandom_range(5) == 0) pc = pick();
      if ($urandom_range(5) == 0) idx_addr = ($urandom_range(3) == 0) ? pc : pick();
      if ($urandom_range(7) == 0) ldram_en = ~ldram_en;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
